// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the fetch-stage controller.
// State encoding, FIFO entry layout and the NOP/HALT opcodes live here.
package if_fetch_ctrl_pkg;

  localparam logic [4:0]  OP_HALT        = 5'h00;
  localparam logic [4:0]  OP_NOP         = 5'h01;
  localparam logic [15:0] NOP_INSTR      = {OP_NOP, 11'd0};
  localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
  localparam logic [15:0] DEF_EXC_VECTOR = 16'h0002;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DROP = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc2;
    logic [15:0] instr;
  } fetch_entry_t;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bundle: decode-side redirects/handshake and the instruction memory port.
// The master modport is the fetch controller; slave is the surrounding pipeline/memory.
interface if_fetch_ctrl_if;

  logic        redirect;
  logic [15:0] redirect_addr;
  logic        exception;
  logic        rti;
  logic [15:0] EPC;
  logic        halt;
  logic        id_ready;

  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;

  logic        if_valid;
  logic [15:0] instr;
  logic [15:0] PC2;
  logic        halted;

  modport master (
    input  redirect, redirect_addr, exception, rti, EPC, halt, id_ready,
    input  imem_done, imem_data,
    output imem_rd, imem_addr,
    output if_valid, instr, PC2, halted
  );

  modport slave (
    output redirect, redirect_addr, exception, rti, EPC, halt, id_ready,
    output imem_done, imem_data,
    input  imem_rd, imem_addr,
    input  if_valid, instr, PC2, halted
  );

endinterface

// File: rtl/if_fetch_ctrl_fetch_fifo2.sv
// Two-entry {PC+2, instr} buffer between instruction memory and decode.
// Slot0 is always the head; flush wins over push/pop.
module fetch_fifo2
  import if_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_entry;
          else               slot1 <= push_entry;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          if (count != 2'd0) count <= count - 2'd1;
        end
        2'b11: begin
          // count stays put; at count 1 the new word becomes the head directly
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_entry;
          end else begin
            slot0 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
  assign head       = slot0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues single-outstanding imem reads,
// buffers responses in a 2-entry FIFO and applies decode's redirects/halt.
//   state   | meaning
//   ST_RUN  | normal fetch; responses are pushed into the FIFO
//   ST_DROP | redirect hit an in-flight read; discard its response, no issue
//   ST_HALT | fetch stopped, responses discarded, left only through reset
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [15:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [15:0] NOP_INSTR  = if_fetch_ctrl_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_ctrl_if.master  bus
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  req_pc2;
  logic [15:0]  pc_seq;
  logic         outstanding;
  logic         fetch_en;
  logic         halted_q;

  logic [1:0]   count;
  logic         head_valid;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  logic any_redir, halt_evt, flush, pop, resp, push, issue;

  assign pc_seq    = pc_inc(pc);
  assign any_redir = (state != ST_HALT) & (bus.exception | bus.rti | bus.redirect);
  assign halt_evt  = (state != ST_HALT) & bus.halt & ~any_redir;
  assign flush     = any_redir | halt_evt;
  assign pop       = head_valid & bus.id_ready;
  assign resp      = outstanding & bus.imem_done;
  assign push      = resp & (state == ST_RUN) & ~flush;
  // imem_done never feeds issue: a free slot is judged from count after this cycle's pop only
  assign issue     = fetch_en & (state == ST_RUN) & ~outstanding & ~flush
                   & ((count - {1'b0, pop}) < 2'd2);

  assign push_entry = '{pc2: req_pc2, instr: bus.imem_data};

  fetch_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      req_pc2     <= 16'h0000;
      outstanding <= 1'b0;
      fetch_en    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      fetch_en <= 1'b1;
      if (issue)     outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;

      case (state)
        ST_RUN, ST_DROP: begin
          if (any_redir) begin
            if (bus.exception) pc <= EXC_VECTOR;
            else if (bus.rti)  pc <= bus.EPC;
            else               pc <= bus.redirect_addr;
            state <= (outstanding & ~bus.imem_done) ? ST_DROP : ST_RUN;
          end else if (halt_evt) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            if (state == ST_DROP && resp) state <= ST_RUN;
            if (issue) begin
              pc      <= pc_seq;
              req_pc2 <= pc_seq;
            end
          end
        end
        ST_HALT: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.imem_rd   = issue;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = head_valid;
  assign bus.instr     = head_valid ? head.instr : NOP_INSTR;
  assign bus.PC2       = head_valid ? head.pc2 : 16'h0000;
  assign bus.halted    = halted_q;

endmodule
